mp_loader: RTL and testbench

- Front-end sequencer for the Montgomery product engine (mon_prod) and its shared operand BRAM.
- Accepts a command plus a stream of DBITS-wide operand words, and writes them into the BRAM through the second write port (WR_ADDR2/WR_DATA2/WR_EN2).
- Drives mon_prod's start/op_code/M/mp_count, detects completion on stop, latches P, and reports done (or timeout).
- Replaces hand-sequenced BRAM preloading and start control with a handshaked block.

---
 rtl/mp_pkg.sv | 21 ++
 rtl/mp_loader_if.sv | 47 ++++
 rtl/mp_word_writer.sv | 58 +++++
 rtl/mp_loader.sv | 118 +++++++++++
 tb/tb_mp_loader.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mp_pkg.sv
// Shared definitions for the Montgomery-product loader slice.
// Holds the opcode encodings, default geometry of the operand BRAM
// and the loader state enum.
package mp_pkg;

  localparam int BITLEN_D  = 1024;
  localparam int ABITS_D   = 8;
  localparam int DBITS_D   = 512;
  localparam int WORDS_D   = 2;    // BITLEN_D / DBITS_D
  localparam int A_BASE_D  = 0;
  localparam int B_BASE_D  = 2;
  localparam int TIMEOUT_D = 4096;

  localparam logic [1:0] OPXX  = 2'd0;
  localparam logic [1:0] OPXM  = 2'd1;
  localparam logic [1:0] OPX1  = 2'd2;
  localparam logic [1:0] OPRSV = 2'd3;

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;

endpackage

// File: rtl/mp_loader_if.sv
// Bundle of every non-clock signal around mp_loader.
//   cmd_*     : command handshake (valid/ready) with op, modulus, count
//   in_*      : operand word stream (valid/ready)
//   wr_*2     : BRAM port-2 write drive
//   start/op_code/M/mp_count/stop/P : mon_prod control and result
//   result/done/err : completion report
// slave = loader side, master = environment side.
interface mp_loader_if
  import mp_pkg::*;
#(
  parameter int BITLEN = BITLEN_D,
  parameter int ABITS  = ABITS_D,
  parameter int DBITS  = DBITS_D
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [BITLEN-1:0] cmd_m;
  logic [9:0]        cmd_count;
  logic              in_valid;
  logic              in_ready;
  logic [DBITS-1:0]  in_data;
  logic [ABITS-1:0]  wr_addr2;
  logic [DBITS-1:0]  wr_data2;
  logic              wr_en2;
  logic              start;
  logic [1:0]        op_code;
  logic [BITLEN-1:0] M;
  logic [9:0]        mp_count;
  logic              stop;
  logic [BITLEN:0]   P;
  logic [BITLEN:0]   result;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_m, cmd_count, in_valid, in_data, stop, P,
    output cmd_ready, in_ready, wr_addr2, wr_data2, wr_en2, start, op_code, M,
           mp_count, result, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_m, cmd_count, in_valid, in_data, stop, P,
    input  cmd_ready, in_ready, wr_addr2, wr_data2, wr_en2, start, op_code, M,
           mp_count, result, done, err
  );
endinterface

// File: rtl/mp_word_writer.sv
// Operand word writer: counts accepted beats, maps beat index to the
// A/B operand address and registers the BRAM port-2 write one cycle
// after the beat.
//   clr      : restart beat count (command accepted)
//   beat     : word accepted this cycle
//   need     : number of beats for the current command
//   in_data  : word to write
//   last     : current beat index is need-1
//   wr_addr2/wr_data2/wr_en2 : registered port-2 drive
module mp_word_writer
  import mp_pkg::*;
#(
  parameter int ABITS  = ABITS_D,
  parameter int DBITS  = DBITS_D,
  parameter int WORDS  = WORDS_D,
  parameter int A_BASE = A_BASE_D,
  parameter int B_BASE = B_BASE_D,
  parameter int NW     = $clog2(2*WORDS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             beat,
  input  logic [NW-1:0]    need,
  input  logic [DBITS-1:0] in_data,
  output logic             last,
  output logic [ABITS-1:0] wr_addr2,
  output logic [DBITS-1:0] wr_data2,
  output logic             wr_en2
);
  logic [NW-1:0]    idx;
  logic [ABITS-1:0] addr;

  assign last = (idx == need - NW'(1));

  // Words 0..WORDS-1 belong to A, the rest to B.
  always_comb begin
    addr = ABITS'(A_BASE) + ABITS'(idx);
    if (idx >= NW'(WORDS)) addr = ABITS'(B_BASE) + ABITS'(idx - NW'(WORDS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      wr_addr2 <= '0;
      wr_data2 <= '0;
      wr_en2   <= 1'b0;
    end else begin
      wr_en2 <= beat;
      if (clr) idx <= '0;
      else if (beat) begin
        idx      <= idx + NW'(1);
        wr_addr2 <= addr;
        wr_data2 <= in_data;
      end
    end
  end
endmodule

// File: rtl/mp_loader.sv
// Front-end sequencer for mon_prod: accepts a command, streams operand
// words into the shared BRAM through port 2, starts mon_prod, waits for
// a rising edge on stop (or a timeout) and reports done/err with P
// latched into result.
//   clk, rst_n : clock, async active-low reset
//   bus        : mp_loader_if.slave (command, word stream, BRAM port 2,
//                mon_prod control, completion report)
module mp_loader
  import mp_pkg::*;
#(
  parameter int BITLEN  = BITLEN_D,
  parameter int ABITS   = ABITS_D,
  parameter int DBITS   = DBITS_D,
  parameter int WORDS   = WORDS_D,
  parameter int A_BASE  = A_BASE_D,
  parameter int B_BASE  = B_BASE_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input logic        clk,
  input logic        rst_n,
  mp_loader_if.slave bus
);
  localparam int NW = $clog2(2*WORDS+1);
  localparam int TW = $clog2(TIMEOUT);

  state_t            state, state_nx;
  logic              err_q, err_nx;
  logic              stop_q;
  logic [TW-1:0]     tcnt;
  logic [NW-1:0]     need;
  logic [1:0]        op_q;
  logic [BITLEN-1:0] m_q;
  logic [9:0]        cnt_q;
  logic [BITLEN:0]   res_q;
  logic              cmd_hs, beat, last, stop_edge, tmo;
  logic [ABITS-1:0]  wa;
  logic [DBITS-1:0]  wd;
  logic              we;

  assign cmd_hs    = bus.cmd_valid && (state == IDLE);
  assign beat      = bus.in_valid && (state == LOAD);
  // stop_q tracks stop in every state, so a stop still high on RUN entry
  // produces no edge.
  assign stop_edge = bus.stop && !stop_q;
  assign tmo       = (tcnt == TW'(TIMEOUT-1));

  mp_word_writer #(
    .ABITS(ABITS), .DBITS(DBITS), .WORDS(WORDS),
    .A_BASE(A_BASE), .B_BASE(B_BASE), .NW(NW)
  ) u_wr (
    .clk(clk), .rst_n(rst_n), .clr(cmd_hs), .beat(beat), .need(need),
    .in_data(bus.in_data), .last(last),
    .wr_addr2(wa), .wr_data2(wd), .wr_en2(we)
  );

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    case (state)
      IDLE:  if (bus.cmd_valid) begin
               state_nx = (bus.cmd_op == OPRSV) ? DONE : LOAD;
               err_nx   = (bus.cmd_op == OPRSV);
             end
      LOAD:  if (beat && last) state_nx = FLUSH;
      FLUSH: state_nx = RUN;
      // A stop edge wins over a simultaneous timeout.
      RUN:   if (stop_edge) begin
               state_nx = DONE;
               err_nx   = 1'b0;
             end else if (tmo) begin
               state_nx = DONE;
               err_nx   = 1'b1;
             end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      err_q  <= 1'b0;
      stop_q <= 1'b0;
      tcnt   <= '0;
      need   <= '0;
      op_q   <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
    end else begin
      state  <= state_nx;
      err_q  <= err_nx;
      stop_q <= bus.stop;
      // Leaves RUN at TIMEOUT-1 at the latest, so it never wraps.
      tcnt   <= (state == RUN) ? tcnt + TW'(1) : '0;
      if (cmd_hs) begin
        op_q  <= bus.cmd_op;
        m_q   <= bus.cmd_m;
        cnt_q <= bus.cmd_count;
        need  <= (bus.cmd_op == OPXM) ? NW'(2*WORDS) : NW'(WORDS);
      end
      if (state == RUN && stop_edge) res_q <= bus.P;
    end
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.in_ready  = (state == LOAD);
  assign bus.start     = (state == RUN);
  assign bus.done      = (state == DONE);
  assign bus.err       = (state == DONE) && err_q;
  assign bus.op_code   = op_q;
  assign bus.M         = m_q;
  assign bus.mp_count  = cnt_q;
  assign bus.result    = res_q;
  assign bus.wr_addr2  = wa;
  assign bus.wr_data2  = wd;
  assign bus.wr_en2    = we;
endmodule

// File: tb/tb_mp_loader.sv
// Bench for mp_loader: table of transactions with expected beat count
// and err, randomized transactions judged by a transaction-level model,
// and hand-written reset / held-stop / directed OPXM sequences.
module tb_mp_loader;
  localparam int BITLEN = 1024;
  localparam int ABITS  = 8;
  localparam int DBITS  = 512;
  localparam int WORDS  = 2;
  localparam int A_BASE = 0;
  localparam int B_BASE = 2;
  localparam int TO     = 64;
  localparam logic [1:0] OPXX = 2'd0, OPXM = 2'd1, OPX1 = 2'd2, OPRSV = 2'd3;

  typedef struct {
    logic [1:0] op;
    int         gapmax;
    int         sdly;     // RUN cycles with stop low before it rises
    bit         held;     // stop high on RUN entry
    int         exp_nw;
    bit         exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   wcount = 0;
  logic [BITLEN:0]  exp_result = '0;
  logic [DBITS-1:0] words [4];
  vec_t tbl [7];

  always #5 clk = ~clk;

  mp_loader_if #(.BITLEN(BITLEN), .ABITS(ABITS), .DBITS(DBITS)) bus ();

  mp_loader #(
    .BITLEN(BITLEN), .ABITS(ABITS), .DBITS(DBITS), .WORDS(WORDS),
    .A_BASE(A_BASE), .B_BASE(B_BASE), .TIMEOUT(TO)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always @(negedge clk) if (bus.wr_en2 === 1'b1) wcount <= wcount + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [BITLEN:0] act, input logic [BITLEN:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (low 200b)", name, act[199:0], exp[199:0]);
    end
  endtask

  function automatic logic [BITLEN:0] rnd_wide();
    logic [BITLEN:0] v;
    v = '0;
    for (int i = 0; i < (BITLEN+32)/32; i++) v = (v << 32) | (BITLEN+1)'($urandom());
    return v;
  endfunction

  // Bit-serial Montgomery product a*b*2^-n mod m (unreduced final).
  function automatic longint mont(longint a, longint b, longint m, int n);
    longint p;
    p = 0;
    for (int i = 0; i < n; i++) begin
      if (((a >> i) & 1) != 0) p = p + b;
      if ((p & 1) != 0) p = p + m;
      p = p >> 1;
    end
    return p;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_in_ready"},  bus.in_ready, 0);
    chk({tag, "_wr_en2"},    bus.wr_en2, 0);
    chk({tag, "_wr_addr2"},  bus.wr_addr2, 0);
    chk({tag, "_wr_data2"},  bus.wr_data2, 0);
    chk({tag, "_start"},     bus.start, 0);
    chk({tag, "_done"},      bus.done, 0);
    chk({tag, "_err"},       bus.err, 0);
    chk({tag, "_op_code"},   bus.op_code, 0);
    chk({tag, "_M"},         bus.M, 0);
    chk({tag, "_mp_count"},  bus.mp_count, 0);
    chk({tag, "_result"},    bus.result, 0);
  endtask

  task automatic txn(input logic [1:0] op, input int gapmax, input int sdly, input bit held,
                     input int exp_nw, input bit exp_err, input logic [BITLEN:0] pval,
                     input logic [BITLEN-1:0] mv, input logic [9:0] cnt);
    int w0, n, runc, sc, exp_runc;
    logic [ABITS-1:0] ea;
    w0 = wcount;
    bus.stop = held;
    bus.P = pval;
    bus.cmd_op = op; bus.cmd_m = mv; bus.cmd_count = cnt; bus.cmd_valid = 1'b1;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin tick(); n++; end
    chk("cmd_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("op_code", bus.op_code, op);
    chk("M", bus.M, mv);
    chk("mp_count", bus.mp_count, cnt);
    if (op == OPRSV) begin
      chk("rsv_done", bus.done, 1);
      chk("rsv_err", bus.err, 1);
      chk("rsv_start", bus.start, 0);
    end else begin
      for (int i = 0; i < exp_nw; i++) begin
        n = $urandom_range(gapmax, 0);
        repeat (n) begin
          bus.in_valid = 1'b0;
          tick();
          chk("gap_wr_en2", bus.wr_en2, 0);
        end
        chk("in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.in_data = words[i];
        tick();
        bus.in_valid = 1'b0;
        ea = (i < WORDS) ? ABITS'(A_BASE + i) : ABITS'(B_BASE + i - WORDS);
        chk("wr_en2", bus.wr_en2, 1);
        chk("wr_addr2", bus.wr_addr2, ea);
        chk("wr_data2", bus.wr_data2, words[i]);
      end
      chk("flush_in_ready", bus.in_ready, 0);
      chk("flush_start", bus.start, 0);
      tick();
      chk("run_start", bus.start, 1);
      chk("run_wr_en2", bus.wr_en2, 0);
      runc = 0; sc = 0;
      while (bus.done !== 1'b1 && runc < TO + 10) begin
        if (held && runc == 2) bus.stop = 1'b0;
        if (runc == sdly) bus.stop = 1'b1;
        sc += int'(bus.start);
        tick();
        runc++;
      end
      exp_runc = (sdly < TO) ? sdly + 1 : TO;
      chk("run_cycles", runc, exp_runc);
      chk("start_held", sc, exp_runc);
      chk("done", bus.done, 1);
      chk("err", bus.err, exp_err);
      chk("done_start", bus.start, 0);
      if (!exp_err) exp_result = pval;
    end
    chk("result", bus.result, exp_result);
    tick();
    chk("idle_ready", bus.cmd_ready, 1);
    chk("idle_done", bus.done, 0);
    chk("writes", wcount - w0, exp_nw);
  endtask

  initial begin
    logic [1:0] op;
    int sdly, nw;
    bit held, e;
    logic [BITLEN:0] pv;

    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_m = '0; bus.cmd_count = '0;
    bus.in_valid = 0; bus.in_data = '0; bus.stop = 0; bus.P = '0;
    repeat (2) tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("post_rst");

    // Directed OPXM: A=435, B=535, M=589, count=10.
    words[0] = 435; words[1] = 0; words[2] = 535; words[3] = 0;
    pv = (BITLEN+1)'(mont(435, 535, 589, 10));
    txn(OPXM, 0, 1, 1'b0, 4, 1'b0, pv, 589, 10);

    tbl[0] = '{op: OPXX,  gapmax: 2, sdly: 3,      held: 1'b0, exp_nw: 2, exp_err: 1'b0};
    tbl[1] = '{op: OPXM,  gapmax: 2, sdly: 5,      held: 1'b0, exp_nw: 4, exp_err: 1'b0};
    tbl[2] = '{op: OPX1,  gapmax: 0, sdly: 0,      held: 1'b0, exp_nw: 2, exp_err: 1'b0};
    tbl[3] = '{op: OPXX,  gapmax: 1, sdly: TO + 5, held: 1'b0, exp_nw: 2, exp_err: 1'b1};
    tbl[4] = '{op: OPRSV, gapmax: 0, sdly: 0,      held: 1'b0, exp_nw: 0, exp_err: 1'b1};
    tbl[5] = '{op: OPXM,  gapmax: 0, sdly: TO - 1, held: 1'b0, exp_nw: 4, exp_err: 1'b0};
    tbl[6] = '{op: OPX1,  gapmax: 1, sdly: 5,      held: 1'b1, exp_nw: 2, exp_err: 1'b0};
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 4; i++) words[i] = DBITS'(rnd_wide());
      txn(tbl[t].op, tbl[t].gapmax, tbl[t].sdly, tbl[t].held, tbl[t].exp_nw,
          tbl[t].exp_err, rnd_wide(), BITLEN'(rnd_wide()), 10'($urandom()));
    end

    // Exact word-gap pattern: word, idle, idle, word.
    words[0] = DBITS'(rnd_wide()); words[1] = DBITS'(rnd_wide());
    bus.cmd_op = OPXX; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = words[0]; tick();
    bus.in_valid = 1'b0; tick();
    chk("gap_write0", bus.wr_en2, 0);
    tick();
    chk("gap_still_load", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.in_data = words[1]; tick();
    bus.in_valid = 1'b0;
    chk("gap_addr1", bus.wr_addr2, A_BASE + 1);
    chk("gap_flush_start", bus.start, 0);
    tick();
    chk("gap_run_start", bus.start, 1);
    bus.stop = 1'b0; tick(); bus.stop = 1'b1; tick();
    chk("gap_done", bus.done, 1);
    exp_result = bus.P;  // P is a bench-driven input, not a DUT output
    tick();

    // Reset during LOAD after one beat.
    bus.stop = 1'b0;
    bus.cmd_op = OPXM; bus.cmd_m = BITLEN'(rnd_wide()); bus.cmd_count = 10'd7; bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = words[0];
    tick();
    bus.in_valid = 1'b0;
    chk("pre_rst_wr_en2", bus.wr_en2, 1);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("mid_rst");
    rst_n = 1'b1;
    exp_result = '0;
    for (int i = 0; i < 4; i++) words[i] = DBITS'(rnd_wide());
    txn(OPXX, 0, 2, 1'b0, 2, 1'b0, rnd_wide(), BITLEN'(rnd_wide()), 10'd3);

    // Randomized transactions against the transaction-level model.
    for (int r = 0; r < 14; r++) begin
      op = ($urandom_range(7, 0) == 0) ? OPRSV : 2'($urandom_range(2, 0));
      nw = (op == OPXM) ? 2 * WORDS : (op == OPRSV) ? 0 : WORDS;
      sdly = ($urandom_range(3, 0) == 0) ? $urandom_range(TO + 3, TO - 2) : $urandom_range(10, 0);
      held = (sdly > 2) && ($urandom_range(1, 0) == 1);
      e = (op == OPRSV) || (sdly >= TO);
      for (int i = 0; i < 4; i++) words[i] = DBITS'(rnd_wide());
      txn(op, $urandom_range(2, 0), sdly, held, nw, e, rnd_wide(),
          BITLEN'(rnd_wide()), 10'($urandom()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
